// File: rtl/dispatch_pkg.sv
// Shared types for the job dispatcher: FSM state encoding and completion counter width.
package dispatch_pkg;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2
  } disp_state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/job_fifo.sv
// Synchronous request FIFO (DEPTH x W) with push/pop, full/empty flags and occupancy count.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd];

  // Storage carries data only, so it stays out of the reset domain.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/job_dispatcher.sv
// Job dispatcher: queues job IDs, issues one start pulse per job and reports each completion.
// Define DISPATCH_TIMEOUT_EN to build the D_WAIT watchdog that aborts a job after TIMEOUT cycles.
module job_dispatcher
  import dispatch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [ID_W-1:0]  req_id,
  output logic             req_ready,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic             cmpl_valid,
  output logic [ID_W-1:0]  cmpl_id,
  output logic             cmpl_err,
  output logic [CNT_W-1:0] job_count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("job_dispatcher: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  disp_state_t                 r_state;
  disp_state_t                 w_next;
  logic                        r_start;
  logic                        r_cmpl_valid;
  logic [ID_W-1:0]             r_cmpl_id;
  logic [ID_W-1:0]             r_cur_id;
  logic [CNT_W-1:0]            r_job_count;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_cmpl;
  logic                        w_timeout;
  logic                        w_full;
  logic                        w_empty;
  logic [ID_W-1:0]             w_fifo_dout;
  logic [$clog2(DEPTH):0]      w_count;

  assign w_push    = req_valid && !w_full;
  assign w_pop     = (r_state == D_IDLE) && !w_empty;
  assign req_ready = (w_count != ($clog2(DEPTH)+1)'(DEPTH));
  assign start      = r_start;
  assign busy       = (r_state != D_IDLE);
  assign cmpl_valid = r_cmpl_valid;
  assign cmpl_id    = r_cmpl_id;
  assign job_count  = r_job_count;

  job_fifo #(.DEPTH(DEPTH), .W(ID_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (req_id),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_next = r_state;
    w_cmpl = 1'b0;
    case (r_state)
      D_IDLE:  if (!w_empty) w_next = D_ISSUE;
      D_ISSUE: w_next = D_WAIT;
      D_WAIT: begin
        if (done || w_timeout) begin
          w_next = D_IDLE;
          w_cmpl = 1'b1;
        end
      end
      default: w_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= D_IDLE;
      r_start      <= 1'b0;
      r_cmpl_valid <= 1'b0;
      r_cmpl_id    <= '0;
      r_job_count  <= '0;
    end else begin
      r_state      <= w_next;
      r_start      <= (w_next == D_ISSUE);
      r_cmpl_valid <= w_cmpl;
      if (w_cmpl) begin
        r_cmpl_id   <= r_cur_id;
        r_job_count <= r_job_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_cur_id <= w_fifo_dout;
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_cmpl_err;

  // Fires on the TIMEOUT-th WAIT cycle; a done in that same cycle still wins.
  assign w_timeout = (r_state == D_WAIT) && (r_wd == WD_W'(TIMEOUT - 1));
  assign cmpl_err  = r_cmpl_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd       <= '0;
      r_cmpl_err <= 1'b0;
    end else begin
      r_wd       <= (r_state == D_WAIT) ? r_wd + 1'b1 : '0;
      r_cmpl_err <= w_cmpl && !done;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign cmpl_err  = 1'b0;
`endif

endmodule
